// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;

  // IDLE: unconfigured, input stream ignored. RUN: legal pattern held, detecting.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Increment value, sticking at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] all_ones;
    all_ones = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= all_ones) ? all_ones : value + 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
import seq_det_pkg::*;

module seq_det_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear first, otherwise a saturating increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
    end
  end

  // Count register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/programmable_sequence_detector.sv
// Runtime-programmable serial bit-pattern detector with a registered match
// pulse and a saturating match counter.
//
// Input qualification: a bit on 'a' is consumed only on a rising edge where
// a_valid=1, the detector is in RUN and cfg_load=0. cfg_load is a one-cycle
// strobe sampled on every edge and always wins; a bit presented in the same
// cycle is discarded. There is no backpressure: the detector accepts every
// qualified bit.
import seq_det_pkg::*;

module programmable_sequence_detector #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = seq_det_pkg::len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               a_valid,
  input  logic               a,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err,
  output state_e             dbg_state_o
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               overlap_q, overlap_d;
  logic               det_q, det_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W:0]     fill_p1;
  logic               cfg_legal;
  logic               accept;
  logic               match;

  // Datapath: shifted history, length mask and masked pattern comparison.
  always_comb begin
    len_mask   = '0;
    hist_shift = {hist_q[MAX_LEN-2:0], a};
    fill_p1    = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    fill_inc   = (fill_q == MAX_LEN_L) ? fill_q : fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
    cfg_legal  = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    accept     = (state_q == RUN) && a_valid && !cfg_load;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    // fill counts fresh bits, so a short history after load or after a
    // non-overlapping match can never produce a match on stale bits.
    match = accept && (fill_p1 >= {1'b0, len_q}) &&
            (((hist_shift ^ pattern_q) & len_mask) == '0);
  end

  // FSM next state plus configuration, history and pulse updates.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    fill_d    = fill_q;
    overlap_d = overlap_q;
    cfg_err_d = cfg_err_q;
    det_d     = 1'b0;
    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      if (cfg_legal) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        cfg_err_d = 1'b0;
        state_d   = RUN;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (a_valid) begin
            hist_d = hist_shift;
            fill_d = (match && !overlap_q) ? '0 : fill_inc;
            det_d  = match;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hist_q    <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      overlap_q <= 1'b0;
      det_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      overlap_q <= overlap_d;
      det_q     <= det_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cfg_load),
    .inc_i   (match),
    .count_o (match_count)
  );

  assign detected    = det_q;
  assign armed       = (state_q == RUN);
  assign cfg_err     = cfg_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_programmable_sequence_detector.sv
// Self-checking bench for programmable_sequence_detector: directed spec
// scenarios with literal expectations plus a randomized stream checked every
// cycle against a queue-based behavioural model.
import seq_det_pkg::*;

module tb_programmable_sequence_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;
  localparam int W       = CNT_W + 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               a_valid;
  logic               a;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic               cfg_err;
  state_e             dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  programmable_sequence_detector #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .a_valid     (a_valid),
    .a           (a),
    .detected    (detected),
    .match_count (match_count),
    .armed       (armed),
    .cfg_err     (cfg_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check_val(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the accepted bits since the last config (or last match when
  // non-overlapping) and checks the newest len bits against the pattern.
  logic [W-1:0]       exp_q[$];
  bit                 m_bits[$];
  bit                 m_run, m_err, m_det, m_ov;
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len, m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_err = 0; m_det = 0; m_ov = 0;
      m_pat = '0; m_len = 0; m_cnt = 0;
      m_bits.delete();
      exp_q.delete();
    end else begin
      bit ok;
      m_det = 0;
      if (cfg_load) begin
        if (int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
          m_run = 1; m_err = 0;
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap;
        end else begin
          m_run = 0; m_err = 1;
        end
        m_bits.delete();
        m_cnt = 0;
      end else if (m_run && a_valid) begin
        m_bits.push_back(a);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        ok = (m_bits.size() >= m_len);
        if (ok) begin
          for (int k = 0; k < m_len; k++) begin
            if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) ok = 0;
          end
        end
        if (ok) begin
          m_det = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_ov) m_bits.delete();
        end
      end
      exp_q.push_back({m_det, CNT_W'(m_cnt), m_run, m_err});
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, expv;
    got = {detected, match_count, armed, cfg_err};
    if (!rst) begin
      check_val("outputs_in_reset", int'(got), 0);
    end else if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      check_val("model_outputs", int'(got), int'(expv));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input int len, input logic ov);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ov;
    a_valid = 1'b0;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic send_bit(input logic b, output logic det);
    a_valid = 1'b1; a = b;
    @(posedge clk); #1;
    a_valid = 1'b0;
    det = detected;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends n bits MSB first; returns a mask with bit i set when the pulse
  // followed the i-th accepted bit (1-based).
  task automatic send_stream(input logic [31:0] bits, input int n, input int gap,
                             output int pulses);
    logic d;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      send_bit(bits[n - 1 - i], d);
      if (d) pulses |= (1 << (i + 1));
      idle_cycles(gap);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   pulses;
    logic d;
    rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; a_valid = 1'b0; a = 1'b0;
    #23;
    check_val("reset_detected", int'(detected), 0);
    check_val("reset_count", int'(match_count), 0);
    check_val("reset_armed", int'(armed), 0);
    check_val("reset_cfg_err", int'(cfg_err), 0);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // len=6 110011, overlap on and off
    load_cfg(8'b0011_0011, 6, 1'b1);
    check_val("armed_after_load", int'(armed), 1);
    check_val("cfg_err_after_load", int'(cfg_err), 0);
    send_stream(32'b1100110011, 10, 0, pulses);
    check_val("p6_ov1_pulses", pulses, (1 << 6) | (1 << 10));
    check_val("p6_ov1_count", int'(match_count), 2);

    load_cfg(8'b0011_0011, 6, 1'b0);
    check_val("count_cleared_on_load", int'(match_count), 0);
    send_stream(32'b1100110011, 10, 0, pulses);
    check_val("p6_ov0_pulses", pulses, (1 << 6));
    check_val("p6_ov0_count", int'(match_count), 1);

    // len=4 1010 over 10101010
    load_cfg(8'b0000_1010, 4, 1'b1);
    send_stream(32'b10101010, 8, 0, pulses);
    check_val("p4_ov1_pulses", pulses, (1 << 4) | (1 << 6) | (1 << 8));
    check_val("p4_ov1_count", int'(match_count), 3);

    load_cfg(8'b0000_1010, 4, 1'b0);
    send_stream(32'b10101010, 8, 0, pulses);
    check_val("p4_ov0_pulses", pulses, (1 << 4) | (1 << 8));
    check_val("p4_ov0_count", int'(match_count), 2);

    // gaps of 3 idle cycles between accepted bits
    load_cfg(8'b0011_0011, 6, 1'b0);
    send_stream(32'b110011, 6, 3, pulses);
    check_val("gap_pulses", pulses, (1 << 6));
    check_val("gap_count", int'(match_count), 1);

    // illegal lengths
    load_cfg(8'hFF, 0, 1'b1);
    check_val("len0_cfg_err", int'(cfg_err), 1);
    check_val("len0_armed", int'(armed), 0);
    send_stream(32'hFF, 8, 0, pulses);
    check_val("len0_pulses", pulses, 0);
    check_val("len0_count", int'(match_count), 0);
    load_cfg(8'hFF, MAX_LEN + 1, 1'b1);
    check_val("len9_cfg_err", int'(cfg_err), 1);
    check_val("len9_armed", int'(armed), 0);
    load_cfg(8'h01, 1, 1'b1);
    check_val("legal_cfg_err", int'(cfg_err), 0);
    check_val("legal_armed", int'(armed), 1);

    // len=1 pattern 1: five ones, count saturates at 3
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, d);
      check_val("len1_pulse", int'(d), 1);
      check_val("len1_count", int'(match_count), (i < 3) ? i + 1 : 3);
    end
    // reset asserted mid-stream: outputs drop at once
    a_valid = 1'b1; a = 1'b1;
    #3 rst = 1'b0;
    #1;
    check_val("midrst_detected", int'(detected), 0);
    check_val("midrst_count", int'(match_count), 0);
    check_val("midrst_armed", int'(armed), 0);
    check_val("midrst_cfg_err", int'(cfg_err), 0);
    a_valid = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    send_bit(1'b1, d);
    check_val("after_rst_no_pulse", int'(d), 0);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      cfg_load    = (r < 4);
      cfg_pattern = MAX_LEN'($urandom);
      cfg_len     = (r == 0) ? LEN_W'($urandom_range(0, 15)) : LEN_W'($urandom_range(1, 4));
      cfg_overlap = 1'($urandom_range(0, 1));
      a_valid     = ($urandom_range(0, 9) < 7);
      a           = 1'($urandom_range(0, 1));
      if (c == 1500) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
    end
    cfg_load = 1'b0; a_valid = 1'b0;
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
